id_ex_control: RTL and testbench

Registered, stall-aware successor to the combinational RV32IM control unit. It decodes the ID-stage instruction into the EX control bundle and registers it in the ID/EX pipeline register. It also owns the stall FSM for multi-cycle M-extension operations and data-memory busy-wait, and inserts bubbles on branch/jump flush. It sits between instruction fetch/ID and the EX stage (ALU, data memory, branch unit).

---
 rtl/rv_ctrl_pkg.sv | 62 ++++++
 rtl/rv_decode.sv | 155 +++++++++++++++
 rtl/id_ex_control.sv | 125 ++++++++++++
 tb/tb_id_ex_control.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32IM ID/EX control path: ALU operation codes,
// load/store/branch/jump selector codes, major opcodes, the registered control
// bundle and the stall FSM state type.
package rv_ctrl_pkg;

  // ALU operations
  localparam logic [4:0] ALU_PASS   = 5'b00000;
  localparam logic [4:0] ALU_ADD    = 5'b00001;
  localparam logic [4:0] ALU_AND    = 5'b00010;
  localparam logic [4:0] ALU_OR     = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SLL    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_SUB    = 5'b01000;
  localparam logic [4:0] ALU_MUL    = 5'b01001;
  localparam logic [4:0] ALU_MULH   = 5'b01010;
  localparam logic [4:0] ALU_MULHU  = 5'b01011;
  localparam logic [4:0] ALU_MULHSU = 5'b01100;
  localparam logic [4:0] ALU_DIV    = 5'b01101;
  localparam logic [4:0] ALU_DIVU   = 5'b01110;
  localparam logic [4:0] ALU_REM    = 5'b01111;
  localparam logic [4:0] ALU_REMU   = 5'b10000;
  localparam logic [4:0] ALU_SLT    = 5'b10001;
  localparam logic [4:0] ALU_SLTU   = 5'b10010;

  localparam logic [2:0] LD_NONE = 3'd0, LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3,
                         LD_LBU = 3'd4, LD_LHU = 3'd5, LD_UPPER = 3'd6;
  localparam logic [1:0] ST_NONE = 2'd0, ST_SB = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3;
  localparam logic [2:0] BR_NONE = 3'd0, BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3,
                         BR_BGE = 3'd4, BR_BLTU = 3'd5, BR_BGEU = 3'd6;
  localparam logic [1:0] JMP_NONE = 2'd0, JMP_JAL = 2'd1, JMP_JALR = 2'd2;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic [4:0] aluop;
    logic       immflag;
    logic       selectwrite;
    logic       writeenable;
    logic       read;
    logic       write;
    logic [2:0] loadsignal;
    logic [1:0] storesignal;
    logic [2:0] branchsignal;
    logic [1:0] jumpsignal;
  } ctrl_t;

  typedef enum logic [1:0] {ST_RUN, ST_MULDIV, ST_MEMWAIT} state_e;

endpackage

// File: rtl/rv_decode.sv
// Purely combinational RV32IM decoder.
//   instr_i  : ID-stage instruction
//   ctrl_o   : decoded control bundle (all zero + illegal=1 when undecodable)
//   is_mul_o : legal MUL/MULH/MULHSU/MULHU
//   is_div_o : legal DIV/DIVU/REM/REMU
module rv_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        is_mul_o,
  output logic        is_div_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ill;
  ctrl_t      c;
  logic       mul_c, div_c;
  logic       unused_fields;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  // Register and immediate fields are consumed downstream, not here.
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    c     = '0;
    ill   = 1'b0;
    mul_c = 1'b0;
    div_c = 1'b0;
    case (opcode)
      OPC_OP: begin
        c.writeenable = 1'b1;
        case (funct7)
          7'b0000000: case (funct3)
            3'b000: c.aluop = ALU_ADD;
            3'b001: c.aluop = ALU_SLL;
            3'b010: c.aluop = ALU_SLT;
            3'b011: c.aluop = ALU_SLTU;
            3'b100: c.aluop = ALU_XOR;
            3'b101: c.aluop = ALU_SRL;
            3'b110: c.aluop = ALU_OR;
            default: c.aluop = ALU_AND;
          endcase
          7'b0100000: case (funct3)
            3'b000: c.aluop = ALU_SUB;
            3'b101: c.aluop = ALU_SRA;
            default: ill = 1'b1;
          endcase
          7'b0000001: begin
            if (!ENABLE_M) ill = 1'b1;
            mul_c = ~funct3[2];
            div_c = funct3[2];
            case (funct3)
              3'b000: c.aluop = ALU_MUL;
              3'b001: c.aluop = ALU_MULH;
              3'b010: c.aluop = ALU_MULHSU;
              3'b011: c.aluop = ALU_MULHU;
              3'b100: c.aluop = ALU_DIV;
              3'b101: c.aluop = ALU_DIVU;
              3'b110: c.aluop = ALU_REM;
              default: c.aluop = ALU_REMU;
            endcase
          end
          default: ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        c.immflag     = 1'b1;
        c.writeenable = 1'b1;
        case (funct3)
          3'b000: c.aluop = ALU_ADD;
          3'b010: c.aluop = ALU_SLT;
          3'b011: c.aluop = ALU_SLTU;
          3'b100: c.aluop = ALU_XOR;
          3'b110: c.aluop = ALU_OR;
          3'b111: c.aluop = ALU_AND;
          3'b001: if (funct7 == 7'b0000000) c.aluop = ALU_SLL; else ill = 1'b1;
          default: begin
            if (funct7 == 7'b0000000)      c.aluop = ALU_SRL;
            else if (funct7 == 7'b0100000) c.aluop = ALU_SRA;
            else                           ill = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        c.selectwrite = 1'b1;
        c.read        = 1'b1;
        c.writeenable = 1'b1;
        case (funct3)
          3'b000: c.loadsignal = LD_LB;
          3'b001: c.loadsignal = LD_LH;
          3'b010: c.loadsignal = LD_LW;
          3'b100: c.loadsignal = LD_LBU;
          3'b101: c.loadsignal = LD_LHU;
          default: ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        c.write = 1'b1;
        case (funct3)
          3'b000: c.storesignal = ST_SB;
          3'b001: c.storesignal = ST_SH;
          3'b010: c.storesignal = ST_SW;
          default: ill = 1'b1;
        endcase
      end
      OPC_BRANCH: case (funct3)
        3'b000: begin c.aluop = ALU_SUB;  c.branchsignal = BR_BEQ;  end
        3'b001: begin c.aluop = ALU_SUB;  c.branchsignal = BR_BNE;  end
        3'b100: begin c.aluop = ALU_SLT;  c.branchsignal = BR_BLT;  end
        3'b101: begin c.aluop = ALU_SLT;  c.branchsignal = BR_BGE;  end
        3'b110: begin c.aluop = ALU_SLTU; c.branchsignal = BR_BLTU; end
        3'b111: begin c.aluop = ALU_SLTU; c.branchsignal = BR_BGEU; end
        default: ill = 1'b1;
      endcase
      OPC_JAL: begin
        c.writeenable = 1'b1;
        c.jumpsignal  = JMP_JAL;
      end
      OPC_JALR: begin
        c.writeenable = 1'b1;
        c.jumpsignal  = JMP_JALR;
        if (funct3 != 3'b000) ill = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        c.aluop       = (opcode == OPC_AUIPC) ? ALU_ADD : ALU_PASS;
        c.loadsignal  = LD_UPPER;
        c.immflag     = 1'b1;
        c.writeenable = 1'b1;
      end
      default: ill = 1'b1;
    endcase

    // An undecodable instruction collapses to a bubble that only carries the flag.
    if (ill) begin
      c         = '0;
      c.illegal = 1'b1;
      mul_c     = 1'b0;
      div_c     = 1'b0;
    end else begin
      c.valid = 1'b1;
    end
  end

  assign ctrl_o   = c;
  assign is_mul_o = mul_c;
  assign is_div_o = div_c;

endmodule

// File: rtl/id_ex_control.sv
// ID/EX control register with stall FSM.
//   CLK, RESET_N          : clock, asynchronous active-low reset
//   INSTRUCTION/INSTR_VALID: ID-stage instruction and its qualifier
//   BUSYWAIT, FLUSH       : data-memory busy, kill the ID instruction
//   STALL                 : freeze PC and IF/ID (decoded from state)
//   remaining outputs     : registered EX control bundle
module id_ex_control
  import rv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32,
  parameter bit ENABLE_M   = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  input  logic        BUSYWAIT,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        CTRL_VALID,
  output logic [4:0]  ALUOP,
  output logic        IMMflag,
  output logic        SELECTWRITE,
  output logic        WRITEENABLE,
  output logic        READ,
  output logic        WRITE,
  output logic [2:0]  LOADSIGNAL,
  output logic [1:0]  STORESIGNAL,
  output logic [2:0]  BRANCHSIGNAL,
  output logic [1:0]  JUMPSIGNAL,
  output logic        ILLEGAL
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  ctrl_t            dec;
  logic             dec_mul, dec_div;
  ctrl_t            ctrl_q, ctrl_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rv_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .instr_i  (INSTRUCTION),
    .ctrl_o   (dec),
    .is_mul_o (dec_mul),
    .is_div_o (dec_div)
  );

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (FLUSH || !INSTR_VALID) begin
          ctrl_d = '0;
        end else begin
          ctrl_d = dec;
          if (dec_mul && (MUL_CYCLES > 1)) begin
            cnt_d   = MUL_LOAD;
            state_d = ST_MULDIV;
          end else if (dec_div && (DIV_CYCLES > 1)) begin
            cnt_d   = DIV_LOAD;
            state_d = ST_MULDIV;
          end else if ((dec.read || dec.write) && BUSYWAIT) begin
            // Memory is already busy as the access is captured: hold it.
            state_d = ST_MEMWAIT;
          end
        end
      end
      ST_MULDIV: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MEMWAIT: begin
        if (!BUSYWAIT) begin
          // Access completed: keep the write-back fields, drop the request.
          ctrl_d.read  = 1'b0;
          ctrl_d.write = 1'b0;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_RUN;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  a_no_flush_while_stalled: assert property (
    @(posedge CLK) disable iff (!RESET_N) (state_q != ST_RUN) |-> !FLUSH
  );

  assign STALL        = (state_q != ST_RUN);
  assign CTRL_VALID   = ctrl_q.valid;
  assign ILLEGAL      = ctrl_q.illegal;
  assign ALUOP        = ctrl_q.aluop;
  assign IMMflag      = ctrl_q.immflag;
  assign SELECTWRITE  = ctrl_q.selectwrite;
  assign WRITEENABLE  = ctrl_q.writeenable;
  assign READ         = ctrl_q.read;
  assign WRITE        = ctrl_q.write;
  assign LOADSIGNAL   = ctrl_q.loadsignal;
  assign STORESIGNAL  = ctrl_q.storesignal;
  assign BRANCHSIGNAL = ctrl_q.branchsignal;
  assign JUMPSIGNAL   = ctrl_q.jumpsignal;

endmodule

// File: tb/tb_id_ex_control.sv
// Directed bench for id_ex_control: expected bundles are queued as each
// instruction is driven and popped when the registered outputs are sampled.
module tb_id_ex_control;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID, BUSYWAIT, FLUSH;

  logic        STALL, CTRL_VALID, IMMflag, SELECTWRITE, WRITEENABLE, READ, WRITE, ILLEGAL;
  logic [4:0]  ALUOP;
  logic [2:0]  LOADSIGNAL, BRANCHSIGNAL;
  logic [1:0]  STORESIGNAL, JUMPSIGNAL;

  logic        nm_STALL, nm_CTRL_VALID, nm_IMMflag, nm_SELECTWRITE, nm_WRITEENABLE;
  logic        nm_READ, nm_WRITE, nm_ILLEGAL;
  logic [4:0]  nm_ALUOP;
  logic [2:0]  nm_LOADSIGNAL, nm_BRANCHSIGNAL;
  logic [1:0]  nm_STORESIGNAL, nm_JUMPSIGNAL;

  int n_checks = 0;
  int n_errors = 0;
  logic [21:0] exp_q[$];

  always #5 CLK = ~CLK;

  id_ex_control #(.MUL_CYCLES(1), .DIV_CYCLES(32), .ENABLE_M(1'b1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .BUSYWAIT(BUSYWAIT), .FLUSH(FLUSH), .STALL(STALL), .CTRL_VALID(CTRL_VALID),
    .ALUOP(ALUOP), .IMMflag(IMMflag), .SELECTWRITE(SELECTWRITE), .WRITEENABLE(WRITEENABLE),
    .READ(READ), .WRITE(WRITE), .LOADSIGNAL(LOADSIGNAL), .STORESIGNAL(STORESIGNAL),
    .BRANCHSIGNAL(BRANCHSIGNAL), .JUMPSIGNAL(JUMPSIGNAL), .ILLEGAL(ILLEGAL)
  );

  id_ex_control #(.MUL_CYCLES(1), .DIV_CYCLES(32), .ENABLE_M(1'b0)) dut_nm (
    .CLK(CLK), .RESET_N(RESET_N), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .BUSYWAIT(BUSYWAIT), .FLUSH(FLUSH), .STALL(nm_STALL), .CTRL_VALID(nm_CTRL_VALID),
    .ALUOP(nm_ALUOP), .IMMflag(nm_IMMflag), .SELECTWRITE(nm_SELECTWRITE),
    .WRITEENABLE(nm_WRITEENABLE), .READ(nm_READ), .WRITE(nm_WRITE),
    .LOADSIGNAL(nm_LOADSIGNAL), .STORESIGNAL(nm_STORESIGNAL),
    .BRANCHSIGNAL(nm_BRANCHSIGNAL), .JUMPSIGNAL(nm_JUMPSIGNAL), .ILLEGAL(nm_ILLEGAL)
  );

  wire [21:0] obs_b = {CTRL_VALID, ILLEGAL, ALUOP, IMMflag, SELECTWRITE, WRITEENABLE,
                       READ, WRITE, LOADSIGNAL, STORESIGNAL, BRANCHSIGNAL, JUMPSIGNAL};
  wire [21:0] nm_b  = {nm_CTRL_VALID, nm_ILLEGAL, nm_ALUOP, nm_IMMflag, nm_SELECTWRITE,
                       nm_WRITEENABLE, nm_READ, nm_WRITE, nm_LOADSIGNAL, nm_STORESIGNAL,
                       nm_BRANCHSIGNAL, nm_JUMPSIGNAL};

  // {valid, illegal, aluop, imm, selwr, we, read, write, load, store, branch, jump}
  function automatic logic [21:0] bnd(logic v, logic il, logic [4:0] op, logic im,
                                      logic sw, logic we, logic rd, logic wr,
                                      logic [2:0] ld, logic [1:0] st,
                                      logic [2:0] br, logic [1:0] jp);
    return {v, il, op, im, sw, we, rd, wr, ld, st, br, jp};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one instruction for one edge, then compare against the queued bundle.
  task automatic issue(string tag, logic [31:0] ins, logic v, logic bw, logic fl,
                       logic [21:0] exp, logic exp_stall);
    logic [21:0] e;
    INSTRUCTION = ins;
    INSTR_VALID = v;
    BUSYWAIT    = bw;
    FLUSH       = fl;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".bundle"}, 32'(obs_b), 32'(e));
    chk({tag, ".stall"}, 32'(STALL), 32'(exp_stall));
    $display("txn %-8s instr=%h obs=%h exp=%h stall=%0b", tag, ins, obs_b, e, STALL);
    INSTR_VALID = 1'b0;
    FLUSH       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [21:0] b_div, b_lw;
    b_div = bnd(1, 0, 5'b01101, 0, 0, 1, 0, 0, 3'd0, 2'd0, 3'd0, 2'd0);
    b_lw  = bnd(1, 0, 5'b00000, 0, 1, 1, 1, 0, 3'd3, 2'd0, 3'd0, 2'd0);

    RESET_N = 1'b0; INSTRUCTION = '0; INSTR_VALID = 1'b0; BUSYWAIT = 1'b0; FLUSH = 1'b0;
    #12;
    chk("reset.bundle", 32'(obs_b), 32'd0);
    chk("reset.stall", 32'(STALL), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    issue("addi", 32'h00500093, 1, 0, 0, bnd(1,0,5'b00001,1,0,1,0,0,3'd0,2'd0,3'd0,2'd0), 1'b1 & 1'b0);

    // DIV: 31 stall cycles with the bundle held; the M-less instance flags it.
    issue("div", 32'h0220C1B3, 1, 0, 0, b_div, 1'b1);
    chk("div_nm.bundle", 32'(nm_b), 32'(bnd(0,1,5'b0,0,0,0,0,0,3'd0,2'd0,3'd0,2'd0)));
    chk("div_nm.stall", 32'(nm_STALL), 32'd0);
    n = 0;
    while (STALL && n < 40) begin
      chk("div.hold", 32'(obs_b), 32'(b_div));
      n++;
      @(posedge CLK); #1;
    end
    chk("div.stall_cycles", 32'(n), 32'd31);
    $display("txn div-stall cycles=%0d", n);

    issue("add", 32'h002081B3, 1, 0, 0, bnd(1,0,5'b00001,0,0,1,0,0,3'd0,2'd0,3'd0,2'd0), 1'b0);
    issue("sub", 32'h402081B3, 1, 0, 0, bnd(1,0,5'b01000,0,0,1,0,0,3'd0,2'd0,3'd0,2'd0), 1'b0);
    issue("mul", 32'h022081B3, 1, 0, 0, bnd(1,0,5'b01001,0,0,1,0,0,3'd0,2'd0,3'd0,2'd0), 1'b0);

    // LW with memory busy for four edges.
    issue("lw", 32'h00012283, 1, 1, 0, b_lw, 1'b1);
    BUSYWAIT = 1'b1;
    n = 0;
    while (STALL && n < 10) begin
      n++;
      if (n == 4) BUSYWAIT = 1'b0;
      @(posedge CLK); #1;
    end
    chk("lw.stall_cycles", 32'(n), 32'd4);
    chk("lw.read_cleared", 32'(obs_b), 32'(bnd(1,0,5'b0,0,1,1,0,0,3'd3,2'd0,3'd0,2'd0)));
    $display("txn lw-wait cycles=%0d obs=%h", n, obs_b);

    issue("sw", 32'h00512023, 1, 0, 0, bnd(1,0,5'b0,0,0,0,0,1,3'd0,2'd3,3'd0,2'd0), 1'b0);
    issue("beq", 32'h00208463, 1, 0, 0, bnd(1,0,5'b01000,0,0,0,0,0,3'd0,2'd0,3'd1,2'd0), 1'b0);
    issue("flush", 32'h002081B3, 1, 0, 1, 22'd0, 1'b0);
    issue("lui", 32'h123450B7, 1, 0, 0, bnd(1,0,5'b00000,1,0,1,0,0,3'd6,2'd0,3'd0,2'd0), 1'b0);
    issue("auipc", 32'h00001097, 1, 0, 0, bnd(1,0,5'b00001,1,0,1,0,0,3'd6,2'd0,3'd0,2'd0), 1'b0);
    issue("jal", 32'h008000EF, 1, 0, 0, bnd(1,0,5'b0,0,0,1,0,0,3'd0,2'd0,3'd0,2'd1), 1'b0);
    issue("novalid", 32'h00500093, 0, 0, 0, 22'd0, 1'b0);
    issue("undef", 32'h0000007F, 1, 0, 0, bnd(0,1,5'b0,0,0,0,0,0,3'd0,2'd0,3'd0,2'd0), 1'b0);

    // Reset in the middle of a divide (21 edges after issue, count at 10).
    issue("div2", 32'h0220C1B3, 1, 0, 0, b_div, 1'b1);
    repeat (21) @(posedge CLK);
    #1;
    chk("div2.still_stalled", 32'(STALL), 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("midreset.bundle", 32'(obs_b), 32'd0);
    chk("midreset.stall", 32'(STALL), 32'd0);
    $display("txn midreset obs=%h stall=%0b", obs_b, STALL);
    @(negedge CLK);
    RESET_N = 1'b1;
    issue("post_rst", 32'h00500093, 1, 0, 0, bnd(1,0,5'b00001,1,0,1,0,0,3'd0,2'd0,3'd0,2'd0), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
